// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and perf counter widths for the pipeline skid register
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int PERF_STALL_W = 32;
  localparam int PERF_FLUSH_W = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating up-counter with synchronous clear
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until all-ones and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with 2-entry skid buffer and flush; PIPE_SKID_PERF_EN adds perf counters
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W        = 256,
  parameter bit                ZERO_ON_FLUSH = 1'b1,
  parameter logic [DATA_W-1:0] RESET_DATA    = '0
`ifdef PIPE_SKID_PERF_EN
  ,
  parameter int                STALL_CNT_W   = PERF_STALL_W,
  parameter int                FLUSH_CNT_W   = PERF_FLUSH_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              exception_flush,
`ifdef PIPE_SKID_PERF_EN
  output logic [STALL_CNT_W-1:0] perf_stall_cnt,
  output logic [FLUSH_CNT_W-1:0] perf_flush_cnt,
`endif
  output logic [1:0]        occupancy
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occupancy_q, occupancy_d;

  logic push;
  logic pop;
  logic flush_taken;
  logic kill;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occupancy_q;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  // A plain flush must not yank the head away from a stalled consumer.
  assign flush_taken = flush & (out_ready | ~out_valid);
  assign kill        = exception_flush | flush_taken;

  // Next state and payload: handshake first, then kill, then reset override.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Any kill drops the same-cycle push; a same-cycle pop was already delivered.
    if (kill) begin
      state_d = ST_EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end

    if (rst) begin
      state_d = ST_EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_d = RESET_DATA;
        skid_d = RESET_DATA;
      end
    end
  end

  // Registered status derived from the next state so it never adds a comb path.
  always_comb begin
    in_ready_d = (state_d != ST_FULL);
    unique case (state_d)
      ST_ONE:  occupancy_d = 2'd1;
      ST_FULL: occupancy_d = 2'd2;
      default: occupancy_d = 2'd0;
    endcase
  end

  // State, payload and status registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    main_q      <= main_d;
    skid_q      <= skid_d;
    in_ready_q  <= in_ready_d;
    occupancy_q <= occupancy_d;
  end

`ifdef PIPE_SKID_PERF_EN
  logic stall_inc;

  assign stall_inc = out_valid & ~out_ready;

  pipe_sat_cnt #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .inc(stall_inc),
    .cnt(perf_stall_cnt)
  );

  pipe_sat_cnt #(
    .W(FLUSH_CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .clr(rst),
    .inc(kill),
    .cnt(perf_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed table-driven bench for pipe_skid_reg
module tb_pipe_skid_reg;

  localparam int              DW    = 16;
  localparam logic [DW-1:0]   RDATA = 16'h5A5A;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic          exception_flush;
  logic [1:0]    occupancy;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0]   perf_stall_cnt;
  logic [1:0]    perf_flush_cnt;
`endif

  int n_checks;
  int n_fails;

  pipe_skid_reg #(
    .DATA_W(DW),
    .ZERO_ON_FLUSH(1'b1),
    .RESET_DATA(RDATA)
`ifdef PIPE_SKID_PERF_EN
    ,
    .STALL_CNT_W(32),
    .FLUSH_CNT_W(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
    .exception_flush(exception_flush),
`ifdef PIPE_SKID_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          fl;
    logic          exc;
    logic          e_ov;
    logic          e_ir;
    logic [1:0]    e_occ;
    logic          chk_d;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic fl, input logic exc,
                     input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                     input logic chk_d, input logic [DW-1:0] e_d);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy; v.fl = fl; v.exc = exc;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.chk_d = chk_d; v.e_d = e_d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic exc);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    flush = fl; exception_flush = exc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; exception_flush = 1'b0;

    //   rst iv din  ordy fl exc | ov ir occ chk data
    add(1, 0, 16'h0, 0, 0, 0,   0, 1, 2'd0, 1, RDATA);        // reset state
    for (int k = 1; k <= 8; k++)                              // streaming
      add(0, 1, DW'(k), 1, 0, 0, 1, 1, 2'd1, 1, DW'(k));
    add(0, 0, 16'h0, 1, 0, 0,   0, 1, 2'd0, 0, 16'h0);        // drain
    add(0, 1, 16'hA, 0, 0, 0,   1, 1, 2'd1, 1, 16'hA);        // backpressure
    add(0, 1, 16'hB, 0, 0, 0,   1, 0, 2'd2, 1, 16'hA);
    add(0, 1, 16'hD, 0, 0, 0,   1, 0, 2'd2, 1, 16'hA);        // blocked push
    add(0, 0, 16'h0, 1, 0, 0,   1, 1, 2'd1, 1, 16'hB);
    add(0, 0, 16'h0, 1, 0, 0,   0, 1, 2'd0, 0, 16'h0);
    add(0, 1, 16'hA, 0, 0, 0,   1, 1, 2'd1, 1, 16'hA);        // flush while stalled
    add(0, 1, 16'hB, 0, 0, 0,   1, 0, 2'd2, 1, 16'hA);
    add(0, 0, 16'h0, 0, 1, 0,   1, 0, 2'd2, 1, 16'hA);
    add(0, 0, 16'h0, 0, 1, 0,   1, 0, 2'd2, 1, 16'hA);
    add(0, 0, 16'h0, 1, 1, 0,   0, 1, 2'd0, 1, 16'h0);        // flush taken
    add(0, 1, 16'h3, 0, 0, 0,   1, 1, 2'd1, 1, 16'h3);
    add(0, 1, 16'h4, 1, 1, 0,   0, 1, 2'd0, 1, 16'h0);        // flush drops push
    add(0, 1, 16'hA, 0, 0, 0,   1, 1, 2'd1, 1, 16'hA);        // exception vs push
    add(0, 1, 16'hB, 0, 0, 0,   1, 0, 2'd2, 1, 16'hA);
    add(0, 1, 16'hC, 0, 0, 1,   0, 1, 2'd0, 1, 16'h0);
    add(0, 0, 16'h0, 1, 0, 0,   0, 1, 2'd0, 1, 16'h0);
    add(0, 1, 16'h6, 0, 0, 0,   1, 1, 2'd1, 1, 16'h6);
    add(0, 1, 16'h7, 0, 0, 1,   0, 1, 2'd0, 1, 16'h0);        // accepted push killed
    add(0, 0, 16'h0, 1, 0, 0,   0, 1, 2'd0, 1, 16'h0);
    add(0, 1, 16'hA, 0, 0, 0,   1, 1, 2'd1, 1, 16'hA);        // reset mid-stream
    add(0, 1, 16'hB, 0, 0, 0,   1, 0, 2'd2, 1, 16'hA);
    add(1, 1, 16'hE, 0, 0, 0,   0, 1, 2'd0, 1, RDATA);
    add(0, 1, 16'h9, 1, 0, 0,   1, 1, 2'd1, 1, 16'h9);
    add(0, 1, 16'h5, 0, 0, 0,   1, 0, 2'd2, 1, 16'h9);        // exception beats held flush
    add(0, 0, 16'h0, 0, 1, 0,   1, 0, 2'd2, 1, 16'h9);
    add(0, 0, 16'h0, 0, 1, 1,   0, 1, 2'd0, 1, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl, vecs[i].exc);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      check($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      if (vecs[i].chk_d)
        check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_d));
    end

    // FIFO order under random-ish stalls: a scoreboard of pushed words.
    begin
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] nxt;
      int            popped;
      logic          do_push, do_pop;
      nxt = 16'h100;
      popped = 0;
      for (int c = 0; c < 200 && popped < 40; c++) begin
        do_push = ($urandom_range(0, 3) != 0) && (nxt < 16'h128);
        do_pop  = ($urandom_range(0, 2) != 0);
        rst = 1'b0; flush = 1'b0; exception_flush = 1'b0;
        in_valid = do_push; in_data = nxt; out_ready = do_pop;
        #1;
        if (out_valid && out_ready) begin
          check("fifo order", 32'(out_data), 32'(exp_q.pop_front()));
          popped++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(nxt);
          nxt = nxt + 1'b1;
        end
        @(posedge clk);
        #1;
        check("fifo occupancy", 32'(occupancy), 32'(exp_q.size()));
      end
      check("fifo delivered", 32'(popped >= 40), 32'd1);
    end

`ifdef PIPE_SKID_PERF_EN
    drive(1, 0, 16'h0, 0, 0, 0);
    check("perf stall after reset", perf_stall_cnt, 32'd0);
    check("perf flush after reset", 32'(perf_flush_cnt), 32'd0);
    drive(0, 1, 16'hA, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 16'h0, 0, 0, 0);
    check("perf stall count", perf_stall_cnt, 32'd3);
    for (int k = 0; k < 5; k++) drive(0, 0, 16'h0, 0, 0, 1);
    check("perf flush saturate", 32'(perf_flush_cnt), 32'd3);
    check("perf stall during kills", perf_stall_cnt, 32'd4);
    drive(1, 0, 16'h0, 0, 0, 0);
    check("perf stall cleared", perf_stall_cnt, 32'd0);
    check("perf flush cleared", 32'(perf_flush_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
